// File: rtl/modn_updown_counter.sv
// Modulo-MOD synchronous up/down counter with load, enable, wrap/saturate mode
// and a carry output for building multi-stage chains (BCD, hh:mm:ss, dividers).
module modn_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             carry_out,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             load_err_q, load_err_d;

    // Comparing against MAX_VAL rather than MOD keeps everything in WIDTH bits,
    // so MOD == 2^WIDTH never needs an extra bit and the increment cannot overshoot.
    always_comb begin
        out_d      = out_q;
        load_err_d = 1'b0;
        if (load) begin
            if (in > MAX_VAL) begin
                out_d      = '0;
                load_err_d = 1'b1;
            end else begin
                out_d = in;
            end
        end else if (out_q > MAX_VAL) begin
            out_d = '0;
        end else if (en) begin
            if (up_dn) begin
                if (out_q == MAX_VAL) out_d = sat ? MAX_VAL : '0;
                else                  out_d = out_q + WIDTH'(1);
            end else begin
                if (out_q == '0) out_d = sat ? '0 : MAX_VAL;
                else             out_d = out_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            load_err_q <= load_err_d;
        end
    end

    assign out       = out_q;
    assign load_err  = load_err_q;
    assign tc        = up_dn ? (out_q == MAX_VAL) : (out_q == '0);
    assign carry_out = tc & en & ~sat;

endmodule
